// File: rtl/call_stack.sv
// Parametrised return-address stack (ring buffer) beside the PC; top is a zero-latency read.
// Build option CALL_STACK_WRAP_EN: a push while full overwrites the oldest entry instead of being rejected.
module call_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  input  logic             clr_err,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wp_r, wp_inc_s, wp_dec_s, wp_nxt_s, waddr_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic             we_s, ovf_set_s, unf_set_s, empty_s, full_s;
  logic             overflow_r, underflow_r;

  assign empty_s = (cnt_r == {CW{1'b0}});
  assign full_s  = (cnt_r == CNT_FULL);

  // Modulo-DEPTH pointer neighbours; DEPTH need not be a power of two.
  always_comb begin
    if (wp_r == LAST_IDX) begin
      wp_inc_s = {PW{1'b0}};
    end else begin
      wp_inc_s = wp_r + PW'(1);
    end
    if (wp_r == {PW{1'b0}}) begin
      wp_dec_s = LAST_IDX;
    end else begin
      wp_dec_s = wp_r - PW'(1);
    end
  end

  // Next-state decode for each push/pop request combination.
  always_comb begin
    we_s      = 1'b0;
    waddr_s   = wp_r;
    wp_nxt_s  = wp_r;
    cnt_nxt_s = cnt_r;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!full_s) begin
          we_s      = 1'b1;
          wp_nxt_s  = wp_inc_s;
          cnt_nxt_s = cnt_r + CW'(1);
        end else begin
          ovf_set_s = 1'b1;
`ifdef CALL_STACK_WRAP_EN
          // Oldest entry sits at wp when full, so overwriting it keeps the newest DEPTH.
          we_s      = 1'b1;
          wp_nxt_s  = wp_inc_s;
`else
          wp_nxt_s  = wp_r;
`endif
        end
      end
      2'b01: begin
        if (!empty_s) begin
          wp_nxt_s  = wp_dec_s;
          cnt_nxt_s = cnt_r - CW'(1);
        end else begin
          unf_set_s = 1'b1;
        end
      end
      2'b11: begin
        if (!empty_s) begin
          // Tail-call: replace the current top in place.
          we_s    = 1'b1;
          waddr_s = wp_dec_s;
        end else begin
          we_s      = 1'b1;
          wp_nxt_s  = wp_inc_s;
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        we_s = 1'b0;
      end
    endcase
  end

  // Pointer, occupancy and sticky flag registers; set wins over clr_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_r        <= {PW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wp_r        <= wp_nxt_s;
      cnt_r       <= cnt_nxt_s;
      overflow_r  <= ovf_set_s | (overflow_r & ~clr_err);
      underflow_r <= unf_set_s | (underflow_r & ~clr_err);
    end
  end

  // Entry storage; not reset, stale contents are hidden by the empty mask on top.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[waddr_s] <= push_data;
    end else begin
      mem_r[waddr_s] <= mem_r[waddr_s];
    end
  end

  // Zero-latency top read, forced to zero while empty.
  always_comb begin
    if (empty_s) begin
      top = {WIDTH{1'b0}};
    end else begin
      top = mem_r[wp_dec_s];
    end
  end

  assign empty     = empty_s;
  assign full      = full_s;
  assign count     = cnt_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule
